// File: rtl/gate_vector_sequencer_if.sv
// -----------------------------------------------------------------------------
// gate_vector_sequencer_if
// Bundles the run handshake, the gate drive/sample lines and the result bus of
// the gate vector sequencer.
//   start     : run request into the sequencer
//   y_in[6:0] : gate outputs {xnor, xor, nor, nand, not(a), or, and}
//   a, b      : registered gate inputs driven by the sequencer
//   busy/done : run in progress / one-cycle completion pulse
//   pass, fail_mask[6:0], err_count[2:0] : run results
//   vec_idx[1:0] : vector currently driven, {a,b} = vec_idx
// master : the sequencer side. slave : the environment (gates + controller).
// -----------------------------------------------------------------------------
interface gate_vector_sequencer_if;
   logic       start;
   logic [6:0] y_in;
   logic       a;
   logic       b;
   logic       busy;
   logic       done;
   logic       pass;
   logic [6:0] fail_mask;
   logic [2:0] err_count;
   logic [1:0] vec_idx;

   modport master (
      input  start, y_in,
      output a, b, busy, done, pass, fail_mask, err_count, vec_idx
   );

   modport slave (
      output start, y_in,
      input  a, b, busy, done, pass, fail_mask, err_count, vec_idx
   );
endinterface

// File: rtl/gate_vector_sequencer.sv
// -----------------------------------------------------------------------------
// gate_vector_sequencer
// Drives the shared a/b inputs of the two-input gate library through the
// vectors 00, 01, 10, 11. Each vector is held for SETTLE_CYCLES cycles, then
// sampled and checked for one cycle against the expected truth table.
// Per-gate mismatches accumulate into fail_mask, mismatching vectors are
// counted in err_count, and pass/done report the run outcome.
// Ports:
//   clk   : system clock, rising-edge
//   rst_n : synchronous active-low reset
//   bus   : gate_vector_sequencer_if.master (start, y_in in; a, b, busy, done,
//           pass, fail_mask, err_count, vec_idx out)
// -----------------------------------------------------------------------------
module gate_vector_sequencer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   gate_vector_sequencer_if.master bus
);

   // A settle time of 0 is treated as 1.
   localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
   localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);
   localparam logic [1:0]       LAST_VEC = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CHECK  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             a_q, a_d;
   logic             b_q, b_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [6:0]       fail_mask_q, fail_mask_d;
   logic [2:0]       err_count_q, err_count_d;
   logic [1:0]       vec_idx_q, vec_idx_d;
   logic [1:0]       vec_nxt;
   logic [6:0]       diff;

   // Truth table of the gate library, in y_in bit order.
   function automatic logic [6:0] expected_y(input logic a_i, input logic b_i);
      return {~(a_i ^ b_i), (a_i ^ b_i), ~(a_i | b_i), ~(a_i & b_i),
              ~a_i, (a_i | b_i), (a_i & b_i)};
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      fail_mask_d = fail_mask_q;
      err_count_d = err_count_q;
      vec_idx_d   = vec_idx_q;
      vec_nxt     = vec_idx_q + 2'd1;
      diff        = bus.y_in ^ expected_y(a_q, b_q);

      case (state_q)
         S_IDLE: begin
            a_d    = 1'b0;
            b_d    = 1'b0;
            busy_d = 1'b0;
            if (bus.start) begin
               state_d     = S_SETTLE;
               vec_idx_d   = 2'd0;
               cnt_d       = '0;
               busy_d      = 1'b1;
               fail_mask_d = '0;
               err_count_d = '0;
               pass_d      = 1'b0;
            end
         end

         S_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_CHECK: begin
            fail_mask_d = fail_mask_q | diff;
            // At most four vectors, so the 3-bit count cannot wrap.
            if (diff != 7'd0) begin
               err_count_d = err_count_q + 3'd1;
            end
            if (vec_idx_q != LAST_VEC) begin
               vec_idx_d = vec_nxt;
               a_d       = vec_nxt[1];
               b_d       = vec_nxt[0];
               cnt_d     = '0;
               state_d   = S_SETTLE;
            end else begin
               // Final vector: the current diff must be folded into pass
               // because fail_mask_q does not yet include it.
               state_d = S_IDLE;
               a_d     = 1'b0;
               b_d     = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = ((fail_mask_q | diff) == 7'd0);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_mask_q <= '0;
         err_count_q <= '0;
         vec_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_mask_q <= fail_mask_d;
         err_count_q <= err_count_d;
         vec_idx_q   <= vec_idx_d;
      end
   end

   assign bus.a         = a_q;
   assign bus.b         = b_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.fail_mask = fail_mask_q;
   assign bus.err_count = err_count_q;
   assign bus.vec_idx   = vec_idx_q;

endmodule
